l2_line_splitter: RTL and testbench
===================================

Name: l2_line_splitter

Overview:
- Sits on the memory side of the L2 cache, between the L2 miss/writeback port (256-bit line) and the 128-bit arbiter/next-level port.
- Converts one L2 line transaction into BEATS sequential 128-bit transactions.
- On reads, assembles the returned beats into one 256-bit line; on writes, slices the captured line into beats.
- Beat k maps to line bits [k*DN_LINE +: DN_LINE] and byte address line_base + k*(DN_LINE/8).

Parameters:
- L2_LINE, 256, L2 cacheline width in bits.
- DN_LINE, 128, downstream beat width in bits.
- BEATS, L2_LINE/DN_LINE, beats per line; must be a power of two and at least 2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- l2_read  in  1  L2 line read (fill) request; held until l2_resp.
- l2_write  in  1  L2 line write (writeback) request; held until l2_resp.
- l2_address  in  ADDR_W  byte address; bits below log2(L2_LINE/8) ignored unless the optional feature is enabled.
- l2_wdata  in  L2_LINE  writeback line.
- l2_rdata  out  L2_LINE  assembled fill line; valid in the l2_resp cycle.
- l2_resp  out  1  one-cycle completion pulse.
- dn_read  out  1  beat read request.
- dn_write  out  1  beat write request.
- dn_address  out  ADDR_W  beat byte address, DN_LINE/8 aligned.
- dn_wdata  out  DN_LINE  beat write data.
- dn_rdata  in  DN_LINE  beat read data; valid when dn_resp=1.
- dn_resp  in  1  beat completion, one per beat.

Behaviour:
- Reset (asynchronous, rst=0):
  - State goes to IDLE; beat counter cleared.
  - All outputs are 0, including l2_rdata and dn_address.
  - Any partially assembled line is discarded.
  - Deasserting reset mid-transaction does not resume it; the L2 re-requests.
- All outputs are registered.
- States: IDLE, BEAT, DONE.
- IDLE:
  - If l2_write or l2_read is sampled high: latch the operation, line base (l2_address with the low log2(L2_LINE/8) bits cleared) and l2_wdata; set beat=0; go to BEAT.
  - If both are high, write wins.
  - dn_resp is ignored in IDLE.
- BEAT:
  - dn_read or dn_write is high, dn_address = base + beat*(DN_LINE/8).
  - dn_wdata = wdata_q[beat*DN_LINE +: DN_LINE].
  - The request is held stable until dn_resp.
  - On dn_resp for a read, capture dn_rdata into rdata_q[beat*DN_LINE +: DN_LINE].
  - On dn_resp with beat < BEATS-1: beat increments; the next cycle presents the next beat. The request stays high with the new address and no idle gap.
  - On dn_resp with beat = BEATS-1: drop dn_read/dn_write; go to DONE.
- DONE:
  - l2_resp=1 for exactly one cycle; l2_rdata holds the assembled line (held until the next accept); go to IDLE.
  - The L2 drops its request in the cycle after l2_resp, so IDLE never re-accepts the same request.
- Latency: request sampled at edge T; beat 0 is driven from T+1. l2_resp is asserted in the cycle after the final dn_resp. Minimum total with single-cycle downstream: BEATS+2 cycles.
- Request changes during BEAT/DONE are ignored; the operation and data were latched at accept.
- The beat counter wraps modulo BEATS with width log2(BEATS). There is no overflow path.

Optional Feature:
- Macro: L2_SPLIT_CRITICAL_FIRST_EN.
- Defined:
  - Beat order starts at the beat containing l2_address (start = l2_address bits [log2(L2_LINE/8)-1 : log2(DN_LINE/8)]).
  - Order wraps modulo BEATS; completion occurs after BEATS beats.
  - Data placement per beat index is unchanged.
- Undefined: always beat 0 first; l2_address low bits are ignored.

Decomposition:
- Shared package l2_split_pkg holds:
  - state enum (IDLE, BEAT, DONE);
  - localparams for beat byte size, line byte size and offset bit positions derived from L2_LINE/DN_LINE.
- One natural sub-module, l2_beat_seq: beat counter, start offset, wrap, last-beat detect and beat address generation.
- The top level holds the FSM and the data registers.

Test Plan:
- Reset: hold rst=0 with l2_read=1 → all outputs 0. Release → dn_read rises one cycle later with dn_address=0x0000_1000 for l2_address=0x0000_1000.
- Read fill: address 0x0000_2040, downstream returns 0xAAAA...(beat0) then 0x5555...(beat1) with 3-cycle latency each.
  - Required: dn_address sequence 0x2040, then 0x2050.
  - Required: l2_rdata = {0x5555..., 0xAAAA...} with a single l2_resp pulse.
- Writeback: l2_wdata = {128'hB, 128'hA}, address 0x80.
  - Required: dn_write beats with wdata A at 0x80, then B at 0x90.
  - Required: one l2_resp; dn_write low in the DONE cycle.
- Simultaneous l2_read and l2_write at 0x100 → write sequence issued; no read beats.
- Reset mid-transaction: assert rst after the beat-0 dn_resp of a read → outputs 0. After release, a fresh read re-issues beat 0 and l2_rdata has no stale beat 0.
- With L2_SPLIT_CRITICAL_FIRST_EN: read at 0x2050 → dn_address order 0x2050, then 0x2040. l2_rdata is still placed by beat index.

Source files
------------

// File: rtl/l2_split_pkg.sv
// Shared types and geometry for the L2 line splitter.
// Line/beat sizes and offset bit positions derive from the two widths.
package l2_split_pkg;

    localparam int L2_LINE    = 256;
    localparam int DN_LINE    = 128;
    localparam int BEATS      = L2_LINE / DN_LINE;
    localparam int ADDR_W     = 32;
    localparam int BEAT_BYTES = DN_LINE / 8;
    localparam int LINE_BYTES = L2_LINE / 8;
    localparam int BEAT_OFF   = $clog2(BEAT_BYTES);
    localparam int LINE_OFF   = $clog2(LINE_BYTES);
    localparam int BEAT_W     = LINE_OFF - BEAT_OFF;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        DONE
    } state_e;

    typedef logic [BEAT_W-1:0]             beat_t;
    typedef logic [ADDR_W-1:0]             addr_t;
    typedef logic [BEATS-1:0][DN_LINE-1:0] line_t;

endpackage

// File: rtl/l2_line_splitter_if.sv
// Memory request/response bus, used at both line width (L2 side)
// and beat width (downstream side).
interface l2_line_splitter_if
    import l2_split_pkg::*;
#(
    parameter int DW = 128
);

    logic          read;
    logic          write;
    addr_t         address;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          resp;

    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );

endinterface

// File: rtl/l2_beat_seq.sv
// Beat sequencer: counter, start offset, wrap, last detect, beat address.
// L2_SPLIT_CRITICAL_FIRST_EN starts at the beat holding l2_address.
module l2_beat_seq
    import l2_split_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  adv,
    input  addr_t addr,
    output beat_t beat,
    output logic  last,
    output beat_t nxt_beat,
    output addr_t nxt_addr
);

    addr_t base_q;
    addr_t base_d;
    beat_t beat_q;
    beat_t cnt_q;
    beat_t start;

    assign base_d = addr & ~addr_t'(LINE_BYTES - 1);

`ifdef L2_SPLIT_CRITICAL_FIRST_EN
    assign start = addr[LINE_OFF-1:BEAT_OFF];
`else
    assign start = '0;
`endif

    // Index wraps naturally at BEAT_W bits; cnt_q tracks beats issued.
    assign nxt_beat = load ? start : beat_q + 1'b1;
    assign nxt_addr = (load ? base_d : base_q)
                    | (addr_t'(nxt_beat) << BEAT_OFF);
    assign last     = (cnt_q == beat_t'(BEATS - 1));
    assign beat     = beat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            beat_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            base_q <= base_d;
            beat_q <= start;
            cnt_q  <= '0;
        end else if (adv) begin
            beat_q <= nxt_beat;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/l2_line_splitter.sv
// Splits one 256-bit L2 line transaction into 128-bit downstream beats.
// Optional macro L2_SPLIT_CRITICAL_FIRST_EN: critical-beat-first ordering.
module l2_line_splitter
    import l2_split_pkg::*;
(
    input logic                clk,
    input logic                rst,
    l2_line_splitter_if.slave  l2,
    l2_line_splitter_if.master dn
);

    state_e state_q;
    state_e state_d;

    logic   wr_q;
    logic   accept;
    logic   adv;
    logic   last;
    logic   dn_read_q;
    logic   dn_write_q;
    logic   l2_resp_q;
    addr_t  dn_addr_q;
    addr_t  nxt_addr;
    beat_t  beat;
    beat_t  nxt_beat;
    line_t  wline;
    line_t  wdata_q;
    line_t  rdata_q;
    logic [DN_LINE-1:0] dn_wdata_q;

    assign wline  = l2.wdata;
    assign accept = (state_q == IDLE) && (l2.read || l2.write);
    assign adv    = (state_q == BEAT) && dn.resp;

    l2_beat_seq u_seq (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .adv      (adv && !last),
        .addr     (l2.address),
        .beat     (beat),
        .last     (last),
        .nxt_beat (nxt_beat),
        .nxt_addr (nxt_addr)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)      state_d = BEAT;
            BEAT:    if (adv && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Outputs are registered; write wins when both requests are high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            dn_read_q  <= 1'b0;
            dn_write_q <= 1'b0;
            dn_addr_q  <= '0;
            dn_wdata_q <= '0;
            l2_resp_q  <= 1'b0;
        end else begin
            l2_resp_q <= adv && last;
            if (accept) begin
                wr_q       <= l2.write;
                wdata_q    <= wline;
                dn_read_q  <= !l2.write;
                dn_write_q <= l2.write;
                dn_addr_q  <= nxt_addr;
                dn_wdata_q <= wline[nxt_beat];
            end
            if (adv) begin
                if (!wr_q) rdata_q[beat] <= dn.rdata;
                if (last) begin
                    dn_read_q  <= 1'b0;
                    dn_write_q <= 1'b0;
                end else begin
                    dn_addr_q  <= nxt_addr;
                    dn_wdata_q <= wdata_q[nxt_beat];
                end
            end
        end
    end

    assign l2.rdata   = rdata_q;
    assign l2.resp    = l2_resp_q;
    assign dn.read    = dn_read_q;
    assign dn.write   = dn_write_q;
    assign dn.address = dn_addr_q;
    assign dn.wdata   = dn_wdata_q;

endmodule

// File: tb/tb_l2_line_splitter.sv
// Directed bench for l2_line_splitter: vector table plus reset sequences.
// Expected beat order follows L2_SPLIT_CRITICAL_FIRST_EN when defined.
module tb_l2_line_splitter;
    import l2_split_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    l2_line_splitter_if #(.DW(L2_LINE)) l2_bus ();
    l2_line_splitter_if #(.DW(DN_LINE)) dn_bus ();

    l2_line_splitter dut (
        .clk (clk),
        .rst (rst),
        .l2  (l2_bus),
        .dn  (dn_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        addr_t        addr;
        logic [255:0] wdata;
        logic [127:0] r0;
        logic [127:0] r1;
        int           lat;
        logic         ewr;
        addr_t        ea0;
        addr_t        ea1;
        logic [127:0] ed0;
        logic [127:0] ed1;
        logic [255:0] erd;
        int           ecyc;
    } vec_t;

    localparam logic [127:0] PA = {16{8'hAA}};
    localparam logic [127:0] P5 = {16{8'h55}};
    localparam logic [127:0] BA = 128'hA;
    localparam logic [127:0] BB = 128'hB;
    localparam logic [127:0] C1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] C2 = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;

    vec_t tv[6];

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, " l2_rdata"}, l2_bus.rdata, '0);
        check({tag, " ctl"},
              {l2_bus.resp, dn_bus.read, dn_bus.write}, '0);
        check({tag, " dn_address"}, dn_bus.address, '0);
        check({tag, " dn_wdata"}, dn_bus.wdata, '0);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        addr_t        ga[2];
        logic [127:0] gd[2];
        logic [1:0]   gk[2];
        int  beats = 0;
        int  wt    = 0;
        int  cyc   = 0;
        bit  fresh = 1'b1;
        bit  done  = 1'b0;
        @(negedge clk);
        l2_bus.read    = v.rd;
        l2_bus.write   = v.wr;
        l2_bus.address = v.addr;
        l2_bus.wdata   = v.wdata;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dn_bus.resp) begin
                dn_bus.resp = 1'b0;
                wt    = 0;
                fresh = 1'b1;
            end
            if (l2_bus.resp) begin
                done = 1'b1;
                check({tag, " latency"}, 256'(cyc), 256'(v.ecyc));
                if (!v.ewr)
                    check({tag, " l2_rdata"}, l2_bus.rdata, v.erd);
                check({tag, " dn idle in DONE"},
                      {dn_bus.read, dn_bus.write}, '0);
            end else if ((dn_bus.read || dn_bus.write) && beats < 2) begin
                if (fresh) begin
                    ga[beats] = dn_bus.address;
                    gd[beats] = dn_bus.wdata;
                    gk[beats] = {dn_bus.read, dn_bus.write};
                    fresh = 1'b0;
                end else begin
                    check({tag, " held addr"}, dn_bus.address, ga[beats]);
                end
                wt++;
                if (wt >= v.lat) begin
                    dn_bus.resp  = 1'b1;
                    dn_bus.rdata = dn_bus.address[BEAT_OFF] ? v.r1 : v.r0;
                    beats++;
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got no l2_resp, required one", tag);
        end
        check({tag, " beats"}, 256'(beats), 256'd2);
        if (beats == 2) begin
            check({tag, " addr0"}, ga[0], v.ea0);
            check({tag, " addr1"}, ga[1], v.ea1);
            check({tag, " kind0"}, gk[0], {!v.ewr, v.ewr});
            check({tag, " kind1"}, gk[1], {!v.ewr, v.ewr});
            if (v.ewr) begin
                check({tag, " wdata0"}, gd[0], v.ed0);
                check({tag, " wdata1"}, gd[1], v.ed1);
            end
        end
        @(negedge clk);
        l2_bus.read  = 1'b0;
        l2_bus.write = 1'b0;
        check({tag, " resp pulse"}, l2_bus.resp, 1'b0);
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 32'h2040, '0, PA, P5, 3, 1'b0,
                  32'h2040, 32'h2050, '0, '0, {P5, PA}, 7};
        tv[1] = '{1'b0, 1'b1, 32'h80, {BB, BA}, '0, '0, 1, 1'b1,
                  32'h80, 32'h90, BA, BB, '0, 3};
        tv[2] = '{1'b1, 1'b1, 32'h100, {C2, C1}, PA, P5, 2, 1'b1,
                  32'h100, 32'h110, C1, C2, '0, 5};
        tv[4] = '{1'b1, 1'b0, 32'hFFFF_FFE0, '0, P5, C1, 2, 1'b0,
                  32'hFFFF_FFE0, 32'hFFFF_FFF0, '0, '0, {C1, P5}, 5};
`ifdef L2_SPLIT_CRITICAL_FIRST_EN
        tv[3] = '{1'b1, 1'b0, 32'h2050, '0, C1, C2, 1, 1'b0,
                  32'h2050, 32'h2040, '0, '0, {C2, C1}, 3};
        tv[5] = '{1'b0, 1'b1, 32'h1234_567F, {C1, C2}, '0, '0, 1, 1'b1,
                  32'h1234_5670, 32'h1234_5660, C1, C2, '0, 3};
`else
        tv[3] = '{1'b1, 1'b0, 32'h2050, '0, C1, C2, 1, 1'b0,
                  32'h2040, 32'h2050, '0, '0, {C2, C1}, 3};
        tv[5] = '{1'b0, 1'b1, 32'h1234_567F, {C1, C2}, '0, '0, 1, 1'b1,
                  32'h1234_5660, 32'h1234_5670, C2, C1, '0, 3};
`endif

        l2_bus.read    = 1'b1;
        l2_bus.write   = 1'b0;
        l2_bus.address = 32'h1000;
        l2_bus.wdata   = '0;
        dn_bus.rdata   = '0;
        dn_bus.resp    = 1'b0;

        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check("first beat read", {dn_bus.read, dn_bus.write}, 2'b10);
        check("first beat addr", dn_bus.address, 32'h1000);
        rst = 1'b0;
        #1;
        outputs_zero("reset in BEAT");
        l2_bus.read = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // stray dn_resp while idle must not disturb the next transaction
        @(negedge clk);
        dn_bus.resp = 1'b1;
        @(negedge clk);
        dn_bus.resp = 1'b0;
        check("idle resp ignored", {dn_bus.read, dn_bus.write, l2_bus.resp}, '0);

        for (int i = 0; i < 6; i++)
            do_txn(tv[i], $sformatf("vec%0d", i));

        @(negedge clk);
        l2_bus.read    = 1'b1;
        l2_bus.address = 32'h3000;
        @(negedge clk);
        check("mid addr0", dn_bus.address, 32'h3000);
        dn_bus.resp  = 1'b1;
        dn_bus.rdata = {8{16'hDEAD}};
        @(negedge clk);
        dn_bus.resp = 1'b0;
        check("mid beat1 addr", dn_bus.address, 32'h3010);
        rst = 1'b0;
        #1;
        outputs_zero("mid reset");
        l2_bus.read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("no resume",
              {dn_bus.read, dn_bus.write, l2_bus.resp}, '0);
        check("no stale line", l2_bus.rdata, '0);

        do_txn('{1'b1, 1'b0, 32'h3000, '0, C2, PA, 1, 1'b0,
                 32'h3000, 32'h3010, '0, '0, {PA, C2}, 3}, "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
